// File: rtl/starbug_rf_arbiter_if.sv
// Bundles the STARBUG lane <-> register-file sharing signals.
// Purely wiring, zero latency.
// Lanes hold write requests until acked; read grants are same-cycle.
interface starbug_rf_arbiter_if #(
    parameter int XLEN    = 32,
    parameter int NLANES  = 2,
    parameter int WQDEPTH = 4
);
    localparam int CW = $clog2(WQDEPTH + 1);

    logic [NLANES-1:0]      LaneRdReq;
    logic [NLANES*5-1:0]    LaneRs1;
    logic [NLANES*5-1:0]    LaneRs2;
    logic [NLANES-1:0]      LaneRdGnt;
    logic [NLANES*XLEN-1:0] LaneR1;
    logic [NLANES*XLEN-1:0] LaneR2;
    logic [NLANES-1:0]      LaneWrReq;
    logic [NLANES*5-1:0]    LaneRd;
    logic [NLANES*XLEN-1:0] LaneWd;
    logic [NLANES-1:0]      LaneWrAck;
    logic [4:0]             a1;
    logic [4:0]             a2;
    logic [XLEN-1:0]        rd1;
    logic [XLEN-1:0]        rd2;
    logic                   we3;
    logic [4:0]             a3;
    logic [XLEN-1:0]        wd3;
    logic [CW-1:0]          WQCount;
    logic                   WQEmpty;

    // arbiter side
    modport slave (
        input  LaneRdReq, LaneRs1, LaneRs2, LaneWrReq, LaneRd, LaneWd, rd1, rd2,
        output LaneRdGnt, LaneR1, LaneR2, LaneWrAck, a1, a2, we3, a3, wd3,
        output WQCount, WQEmpty
    );

    // lanes + register-file side
    modport master (
        output LaneRdReq, LaneRs1, LaneRs2, LaneWrReq, LaneRd, LaneWd, rd1, rd2,
        input  LaneRdGnt, LaneR1, LaneR2, LaneWrAck, a1, a2, we3, a3, wd3,
        input  WQCount, WQEmpty
    );
endinterface

// File: rtl/starbug_rf_arbiter.sv
// Shares one 2R/1W register file among NLANES lanes: round-robin reads, queued writes with bypass.
// Read grant/data combinational (same cycle); writes drain from the queue one per cycle, >=1 cycle after ack.
// Writes are acked in lane order while free slots remain; unacked lanes must hold their request.
module starbug_rf_arbiter #(
    parameter int XLEN    = 32,
    parameter int NLANES  = 2,
    parameter int WQDEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    starbug_rf_arbiter_if.slave   bus
);
    localparam int PW = $clog2(WQDEPTH);
    localparam int CW = $clog2(WQDEPTH + 1);
    localparam int LW = (NLANES > 1) ? $clog2(NLANES) : 1;

    logic [LW-1:0]   rd_ptr;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic [4:0]      q_rd [WQDEPTH];
    logic [XLEN-1:0] q_wd [WQDEPTH];

    logic            gnt_vld;
    logic [LW-1:0]   gnt_idx;
    logic [LW-1:0]   scan_idx;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            deq;

    logic [NLANES-1:0] enq_en;
    logic [PW-1:0]     enq_pos [NLANES];
    logic [CW-1:0]     n_enq;
    logic [CW-1:0]     slots;

    // Youngest pending value for rs from the start-of-cycle queue, else the regfile; x0 is always 0.
    function automatic logic [XLEN-1:0] lookup(input logic [4:0] rs, input logic [XLEN-1:0] rf_dat);
        logic [PW-1:0] idx;
        lookup = rf_dat;
        for (int k = 0; k < WQDEPTH; k++) begin
            idx = head + PW'(k);
            if (CW'(k) < count && q_rd[idx] == rs)
                lookup = q_wd[idx];
        end
        if (rs == 5'd0)
            lookup = '0;
    endfunction

    // Round-robin read grant starting at rd_ptr, plus address and bypassed data for the winner.
    always_comb begin
        gnt_vld       = 1'b0;
        gnt_idx       = '0;
        scan_idx      = '0;
        rs1           = '0;
        rs2           = '0;
        bus.LaneRdGnt = '0;
        bus.LaneR1    = '0;
        bus.LaneR2    = '0;
        for (int k = 0; k < NLANES; k++) begin
            scan_idx = LW'((int'(rd_ptr) + k) % NLANES);
            if (!reset && !gnt_vld && bus.LaneRdReq[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx;
            end
        end
        if (gnt_vld) begin
            rs1 = bus.LaneRs1[int'(gnt_idx)*5 +: 5];
            rs2 = bus.LaneRs2[int'(gnt_idx)*5 +: 5];
            bus.LaneRdGnt[gnt_idx] = 1'b1;
            bus.LaneR1[int'(gnt_idx)*XLEN +: XLEN] = lookup(rs1, bus.rd1);
            bus.LaneR2[int'(gnt_idx)*XLEN +: XLEN] = lookup(rs2, bus.rd2);
        end
        bus.a1 = rs1;
        bus.a2 = rs2;
    end

    // Head of queue drives the write port; suppressed during reset so pending entries are discarded.
    always_comb begin
        deq         = !reset && (count != '0);
        bus.we3     = deq;
        bus.a3      = deq ? q_rd[head] : 5'd0;
        bus.wd3     = deq ? q_wd[head] : '0;
        bus.WQCount = count;
        bus.WQEmpty = (count == '0);
    end

    // Accept writes in lane order against start-of-cycle free space; x0 writes are acked but dropped.
    always_comb begin
        bus.LaneWrAck = '0;
        enq_en        = '0;
        n_enq         = '0;
        slots         = CW'(WQDEPTH) - count;
        for (int i = 0; i < NLANES; i++) begin
            enq_pos[i] = tail + PW'(n_enq);
            if (!reset && bus.LaneWrReq[i] && slots != '0) begin
                bus.LaneWrAck[i] = 1'b1;
                if (bus.LaneRd[i*5 +: 5] != 5'd0) begin
                    enq_en[i] = 1'b1;
                    n_enq     = n_enq + CW'(1);
                    slots     = slots - CW'(1);
                end
            end
        end
    end

    // Pointer and occupancy state; read pointer advances past the granted lane.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
        end else begin
            if (gnt_vld)
                rd_ptr <= (int'(gnt_idx) == NLANES - 1) ? '0 : gnt_idx + LW'(1);
            if (deq)
                head <= head + PW'(1);
            tail  <= tail + PW'(n_enq);
            count <= count + n_enq - CW'(deq);
        end
    end

    // Queue payload storage; higher lanes land at later slots so they are younger.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NLANES; i++) begin
            if (enq_en[i]) begin
                q_rd[enq_pos[i]] <= bus.LaneRd[i*5 +: 5];
                q_wd[enq_pos[i]] <= bus.LaneWd[i*XLEN +: XLEN];
            end
        end
    end
endmodule

// File: tb/tb_starbug_rf_arbiter.sv
// Directed bench for starbug_rf_arbiter (NLANES=2, WQDEPTH=4) with a behavioural register file.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Each step's expected values are worked out by hand from the block's behaviour.
module tb_starbug_rf_arbiter;
    localparam int XLEN    = 32;
    localparam int NLANES  = 2;
    localparam int WQDEPTH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [XLEN-1:0] rf [32];

    starbug_rf_arbiter_if #(.XLEN(XLEN), .NLANES(NLANES), .WQDEPTH(WQDEPTH)) bus ();

    starbug_rf_arbiter #(.XLEN(XLEN), .NLANES(NLANES), .WQDEPTH(WQDEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // register file: combinational read, write on rising edge, x0 hardwired
    assign bus.rd1 = rf[bus.a1];
    assign bus.rd2 = rf[bus.a2];
    always @(posedge clk) if (bus.we3 && bus.a3 != 5'd0) rf[bus.a3] <= bus.wd3;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input int l, input logic req, input logic [4:0] s1, input logic [4:0] s2);
        bus.LaneRdReq[l]     = req;
        bus.LaneRs1[l*5 +: 5] = s1;
        bus.LaneRs2[l*5 +: 5] = s2;
    endtask

    task automatic set_wr(input int l, input logic req, input logic [4:0] d, input logic [XLEN-1:0] w);
        bus.LaneWrReq[l]         = req;
        bus.LaneRd[l*5 +: 5]     = d;
        bus.LaneWd[l*XLEN +: XLEN] = w;
    endtask

    task automatic idle();
        for (int l = 0; l < NLANES; l++) begin
            set_rd(l, 1'b0, 5'd0, 5'd0);
            set_wr(l, 1'b0, 5'd0, '0);
        end
    endtask

    initial begin
        for (int k = 0; k < 32; k++) rf[k] = '0;

        // reset held two cycles with every request asserted
        set_rd(0, 1'b1, 5'd1, 5'd2);
        set_rd(1, 1'b1, 5'd3, 5'd4);
        set_wr(0, 1'b1, 5'd1, 32'h1);
        set_wr(1, 1'b1, 5'd2, 32'h2);
        @(negedge clk); #1;
        chk("rst_gnt_c0", 64'(bus.LaneRdGnt), 64'h0);
        chk("rst_ack_c0", 64'(bus.LaneWrAck), 64'h0);
        @(negedge clk); #1;
        chk("rst_gnt_c1", 64'(bus.LaneRdGnt), 64'h0);
        chk("rst_ack_c1", 64'(bus.LaneWrAck), 64'h0);
        chk("rst_we3", 64'(bus.we3), 64'h0);
        reset = 1'b0;
        idle();
        #1;
        chk("post_rst_we3", 64'(bus.we3), 64'h0);
        chk("post_rst_empty", 64'(bus.WQEmpty), 64'h1);
        chk("post_rst_count", 64'(bus.WQCount), 64'h0);
        chk("post_rst_gnt", 64'(bus.LaneRdGnt), 64'h0);
        chk("post_rst_a1", 64'(bus.a1), 64'h0);
        chk("post_rst_a3", 64'(bus.a3), 64'h0);

        // round robin: both lanes requesting, grants alternate starting at lane 0
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            set_rd(0, 1'b1, 5'd3, 5'd0);
            set_rd(1, 1'b1, 5'd4, 5'd0);
            #1;
            chk($sformatf("rr_gnt%0d", c), 64'(bus.LaneRdGnt), (c % 2 == 0) ? 64'h1 : 64'h2);
            chk($sformatf("rr_a1_%0d", c), 64'(bus.a1), (c % 2 == 0) ? 64'd3 : 64'd4);
        end

        // bypass: lane0 writes x5, lane1 reads it next cycle while it drains
        @(negedge clk); idle();
        set_wr(0, 1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        chk("byp_ack", 64'(bus.LaneWrAck), 64'h1);
        chk("byp_we3_c0", 64'(bus.we3), 64'h0);
        @(negedge clk); idle();
        set_rd(1, 1'b1, 5'd5, 5'd0);
        #1;
        chk("byp_gnt", 64'(bus.LaneRdGnt), 64'h2);
        chk("byp_r1", 64'(bus.LaneR1), {32'hDEADBEEF, 32'h0});
        chk("byp_we3", 64'(bus.we3), 64'h1);
        chk("byp_a3", 64'(bus.a3), 64'd5);
        chk("byp_wd3", 64'(bus.wd3), 64'hDEADBEEF);
        chk("byp_count", 64'(bus.WQCount), 64'd1);
        @(negedge clk); idle();
        #1;
        chk("byp_drained_empty", 64'(bus.WQEmpty), 64'h1);
        chk("byp_drained_we3", 64'(bus.we3), 64'h0);
        @(negedge clk); idle();
        set_rd(1, 1'b1, 5'd5, 5'd0);
        #1;
        chk("rf_r1", 64'(bus.LaneR1), {32'hDEADBEEF, 32'h0});

        // queue full behaviour: both lanes write every cycle
        @(negedge clk); idle();
        set_wr(0, 1'b1, 5'd8, 32'hA0);
        set_wr(1, 1'b1, 5'd9, 32'hB0);
        #1;
        chk("full_ack_c0", 64'(bus.LaneWrAck), 64'h3);
        chk("full_cnt_c0", 64'(bus.WQCount), 64'd0);
        @(negedge clk);
        set_wr(0, 1'b1, 5'd10, 32'hA1);
        set_wr(1, 1'b1, 5'd11, 32'hB1);
        #1;
        chk("full_ack_c1", 64'(bus.LaneWrAck), 64'h3);
        chk("full_cnt_c1", 64'(bus.WQCount), 64'd2);
        chk("full_a3_c1", 64'(bus.a3), 64'd8);
        chk("full_wd3_c1", 64'(bus.wd3), 64'hA0);
        @(negedge clk);
        set_wr(0, 1'b1, 5'd12, 32'hA2);
        set_wr(1, 1'b1, 5'd13, 32'hB2);
        #1;
        chk("full_ack_c2", 64'(bus.LaneWrAck), 64'h1);
        chk("full_cnt_c2", 64'(bus.WQCount), 64'd3);
        chk("full_a3_c2", 64'(bus.a3), 64'd9);
        @(negedge clk);
        set_wr(0, 1'b1, 5'd14, 32'hA3);
        #1;
        chk("full_ack_c3", 64'(bus.LaneWrAck), 64'h1);
        chk("full_cnt_c3", 64'(bus.WQCount), 64'd3);
        chk("full_a3_c3", 64'(bus.a3), 64'd10);
        @(negedge clk);
        set_wr(0, 1'b0, 5'd0, '0);
        #1;
        chk("full_ack_c4", 64'(bus.LaneWrAck), 64'h2);
        chk("full_a3_c4", 64'(bus.a3), 64'd11);
        @(negedge clk); idle(); #1;
        chk("full_a3_c5", 64'(bus.a3), 64'd12);
        chk("full_cnt_c5", 64'(bus.WQCount), 64'd3);
        @(negedge clk); #1;
        chk("full_a3_c6", 64'(bus.a3), 64'd14);
        chk("full_wd3_c6", 64'(bus.wd3), 64'hA3);
        @(negedge clk); #1;
        chk("full_a3_c7", 64'(bus.a3), 64'd13);
        chk("full_wd3_c7", 64'(bus.wd3), 64'hB2);
        chk("full_cnt_c7", 64'(bus.WQCount), 64'd1);
        @(negedge clk); #1;
        chk("full_cnt_c8", 64'(bus.WQCount), 64'd0);
        chk("full_we3_c8", 64'(bus.we3), 64'h0);

        // same register written by both lanes in one bundle: lane1 is younger
        @(negedge clk); idle();
        set_wr(0, 1'b1, 5'd7, 32'h11);
        set_wr(1, 1'b1, 5'd7, 32'h22);
        #1;
        chk("ord_ack", 64'(bus.LaneWrAck), 64'h3);
        @(negedge clk); idle();
        set_rd(0, 1'b1, 5'd7, 5'd7);
        #1;
        chk("ord_gnt", 64'(bus.LaneRdGnt), 64'h1);
        chk("ord_r1", 64'(bus.LaneR1), 64'h22);
        chk("ord_r2", 64'(bus.LaneR2), 64'h22);
        chk("ord_wd3_first", 64'(bus.wd3), 64'h11);
        @(negedge clk); idle(); #1;
        chk("ord_wd3_second", 64'(bus.wd3), 64'h22);
        chk("ord_a3_second", 64'(bus.a3), 64'd7);
        // read x7 from regfile while lane1 queues a new x7 in the same cycle
        @(negedge clk); idle();
        set_rd(0, 1'b1, 5'd7, 5'd0);
        set_wr(1, 1'b1, 5'd7, 32'h33);
        #1;
        chk("ord_rd_after_drain", 64'(bus.LaneR1), 64'h22);
        chk("ord_gnt2", 64'(bus.LaneRdGnt), 64'h1);
        chk("ord_ack2", 64'(bus.LaneWrAck), 64'h2);
        @(negedge clk); idle(); #1;
        chk("ord_wd3_new", 64'(bus.wd3), 64'h33);

        // x0 writes are acked but never queued; x0 reads return zero
        @(negedge clk); idle();
        set_wr(0, 1'b1, 5'd0, 32'h55);
        #1;
        chk("x0_ack", 64'(bus.LaneWrAck), 64'h1);
        @(negedge clk); idle();
        set_rd(0, 1'b1, 5'd0, 5'd0);
        #1;
        chk("x0_count", 64'(bus.WQCount), 64'd0);
        chk("x0_we3", 64'(bus.we3), 64'h0);
        chk("x0_r1", 64'(bus.LaneR1), 64'h0);

        // mid-operation reset with three entries pending
        @(negedge clk); idle();
        set_wr(0, 1'b1, 5'd1, 32'h1);
        set_wr(1, 1'b1, 5'd2, 32'h2);
        #1;
        chk("mrst_ack0", 64'(bus.LaneWrAck), 64'h3);
        @(negedge clk);
        set_wr(0, 1'b1, 5'd3, 32'h3);
        set_wr(1, 1'b1, 5'd4, 32'h4);
        #1;
        chk("mrst_ack1", 64'(bus.LaneWrAck), 64'h3);
        chk("mrst_cnt1", 64'(bus.WQCount), 64'd2);
        @(negedge clk); idle();
        reset = 1'b1;
        #1;
        chk("mrst_cnt_pre", 64'(bus.WQCount), 64'd3);
        chk("mrst_we3_in_rst", 64'(bus.we3), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mrst_cnt_post", 64'(bus.WQCount), 64'd0);
        chk("mrst_we3_post", 64'(bus.we3), 64'h0);
        chk("mrst_empty_post", 64'(bus.WQEmpty), 64'h1);
        @(negedge clk); #1;
        chk("mrst_rf1_drained", 64'(rf[1]), 64'h1);
        chk("mrst_rf2_dropped", 64'(rf[2]), 64'h0);
        chk("mrst_rf4_dropped", 64'(rf[4]), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
